// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy-width helper and stats counter width for pipe_stage_chain
package pipe_pkg;
  localparam int STATS_WIDTH = 32;
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid+data register (clk, reset active-low sync, load, clear, src_valid, src_data -> valid, data); reset or clear zeroes it, load copies src, else holds
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk)
    if (!reset || clear) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= src_valid;
      data  <= src_data;
    end
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: ready/valid register chain with bubble collapse, flush and occupancy (clk, reset active-low sync, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, occupancy, plus stall_cycles when PIPE_STAGE_CHAIN_STATS_EN is defined)
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
`ifdef PIPE_STAGE_CHAIN_STATS_EN
  output logic [STATS_WIDTH-1:0]        stall_cycles,
`endif
  output logic [occ_width(STAGES)-1:0]  occupancy
);
  localparam int OW = occ_width(STAGES);
  logic [STAGES-1:0]            vld;
  logic [STAGES:0]              rdy;
  logic [STAGES:0][WIDTH-1:0]   dat;
  logic                         in_fire;
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) rdy[i] = !vld[i] | rdy[i+1];
  end
  assign in_ready  = rdy[0] & !flush;
  assign in_fire   = in_valid & in_ready;
  assign dat[0]    = in_data;
  assign out_valid = vld[STAGES-1] & !flush;
  assign out_data  = dat[STAGES];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic sv;
    if (s == 0) begin : g_head
      assign sv = in_fire;
    end else begin : g_tail
      assign sv = vld[s-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .load      (rdy[s]),
      .clear     (flush),
      .src_valid (sv),
      .src_data  (dat[s]),
      .valid     (vld[s]),
      .data      (dat[s+1])
    );
  end
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OW'(vld[i]);
  end
`ifdef PIPE_STAGE_CHAIN_STATS_EN
  always_ff @(posedge clk)
    if (!reset) stall_cycles <= '0;
    else if (vld[STAGES-1] & !out_ready & !flush) stall_cycles <= stall_cycles + 1'b1;
`endif
endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised ready/valid pipeline register chain for the multicore MIPS datapath. It replaces hand-wired enable/clear flop stages between pipeline sections and carries per-stage valid bits, so bubbles collapse under backpressure. It also provides a single-cycle flush and an occupancy count. It sits between producer and consumer units, for example fetch→decode queueing or the memory-response return path.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- STAGES, 2, number of register stages (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  producer offers in_data
- in_ready  out  1  chain accepts in_data this cycle
- in_data  in  WIDTH  producer payload
- out_valid  out  1  stage STAGES-1 holds a valid entry
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WIDTH  payload of stage STAGES-1
- occupancy  out  $clog2(STAGES+1)  number of valid stages

## Operation
- Each stage i holds valid[i] and data[i]. Stage 0 is the input side; stage STAGES-1 drives out_*.
- The ready chain is combinational: rdy[STAGES-1] = !valid[STAGES-1] | out_ready, and rdy[i] = !valid[i] | rdy[i+1].
- in_ready = rdy[0] & !flush.
- Stage i loads from stage i-1 (stage 0 loads from the input) when rdy[i] is 1. It takes valid[i-1] and data[i-1]. For stage 0 the source valid is in_valid & in_ready.
- A stage that is not ready holds its contents.
- Bubble collapse: an invalid stage always accepts, so a gap closes even while the output is stalled.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Flush: out_valid is forced to 0 during a flush cycle. On the next edge all valid[] clear and all data[] clear to 0. No transfer occurs on either side in a flush cycle.
- occupancy is the registered popcount of valid[], updated on the same edge as valid[].
- Data is never modified. Ordering is strictly FIFO. Data in an invalid stage is don't-care but is reset and flushed to 0.

## Timing
- Reset (reset==0 at an edge):
  - all valid[] and data[] become 0, and occupancy becomes 0
  - in_ready = 1 and out_valid = 0 once reset is released
- Reset overrides flush and every transfer. Reset mid-stream drops all entries with no output pulse.
- Latency: an entry accepted at edge k into an empty chain with out_ready held at 1 shows out_valid=1 after edge k+STAGES-1. That means STAGES cycles from the in_valid cycle to the out_valid cycle.
- Throughput: 1 entry/cycle when out_ready=1 continuously.
- Full: occupancy==STAGES and out_ready=0 give in_ready=0. If out_ready=1 while full, in_ready=1 in the same cycle (pass-through of readiness).
- Simultaneous input and output transfer when full: occupancy is unchanged.
- Flush asserted together with in_valid: the input is dropped (in_ready=0).
- out_valid and out_data must stay stable while out_valid & !out_ready.

## Configuration
- PIPE_STAGE_CHAIN_STATS_EN
  - Defined: adds output port stall_cycles (out, 32). It counts cycles with valid[STAGES-1] & !out_ready & !flush, and wraps at 2^32-1 → 0. Reset clears it; flush does not.
  - Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - function occ_width(stages) returning $clog2(stages+1)
  - localparam STATS_WIDTH = 32
- One sub-module, pipe_stage: a single valid+data register with inputs load, src_valid, src_data and clear. The chain is a generate loop of STAGES instances plus the ready chain and popcount.

## Test plan
- Reset: assert reset=0 for 2 cycles with in_valid=1 and in_data=0xDEADBEEF. Required: out_valid=0, occupancy=0, in_ready=1 after release.
- Latency/throughput: STAGES=3, out_ready=1, stream 0x1..0x8 back-to-back. Required: 0x1 on out_data 3 cycles after its in_valid cycle, then one value per cycle in order, with in_ready constantly 1.
- Backpressure/full: STAGES=2, out_ready=0, push 0xA,0xB,0xC. Required: 0xA,0xB accepted, occupancy=2, in_ready=0 while 0xC is held. Then set out_ready=1. Required: 0xA out and 0xC accepted in the same cycle, occupancy stays 2.
- Bubble collapse: STAGES=4, out_ready=0. Push 0x11, idle 2 cycles, then push 0x22. Required: occupancy=2 and both entries in stages 3 and 2. Release out_ready. Required: 0x11 then 0x22 on consecutive cycles.
- Flush: with occupancy=3, pulse flush while in_valid=1 with data 0x55. Required: out_valid=0 and in_ready=0 in the flush cycle, occupancy=0 next cycle, and 0x55 never appears on the output.
- Stats (with PIPE_STAGE_CHAIN_STATS_EN): hold out_ready=0 for 5 cycles with out_valid=1. Required: stall_cycles=5. A flush does not clear it; reset does.
